in_pe_phase_update: RTL and testbench

- Per-PE phase-update stage directly upstream of the PE phase randomiser.
- Accepts a serial stream of neighbour (phase, coupling weight) beats and accumulates the local field `h = bias + Σ w_j·s_j`.
- Decides the new self phase from the sign of the field and presents it on `self_phase`, which drives the randomiser's `in_self_phase` input.
- Phase encoding: `phase_t` is 1 bit; 0 = spin +1, 1 = spin −1.

---
 rtl/in_pe_phase_update_pkg.sv | 36 +++
 rtl/in_pe_phase_update.sv | 159 +++++++++++++++
 tb/tb_in_pe_phase_update.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/in_pe_phase_update_pkg.sv
// -----------------------------------------------------------------------------
// in_pe_phase_update_pkg
//   Shared types and constants for the PE phase-update stage.
//   phase_t        : 1-bit phase, 0 = spin +1, 1 = spin -1
//   phase_t_reg    : registered flavour of phase_t
//   PE_N_NEIGH     : default neighbour beats per update
//   PE_W_W         : default signed weight/bias width
//   PE_ACC_W       : accumulator width derived from the two above
//   weight_t       : signed coupling weight
//   field_t        : signed local field
//   pe_upd_state_e : update controller states
// -----------------------------------------------------------------------------
`ifndef in_PE_phase_update_DEF
`define in_PE_phase_update_DEF

package in_pe_phase_update_pkg;

  typedef logic   phase_t;
  typedef phase_t phase_t_reg;

  localparam int PE_N_NEIGH = 8;
  localparam int PE_W_W     = 4;
  localparam int PE_ACC_W   = PE_W_W + $clog2(PE_N_NEIGH + 1) + 1;

  typedef logic signed [PE_W_W-1:0]   weight_t;
  typedef logic signed [PE_ACC_W-1:0] field_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DECIDE = 2'd2
  } pe_upd_state_e;

endpackage

`endif

// File: rtl/in_pe_phase_update.sv
// -----------------------------------------------------------------------------
// in_pe_phase_update
//   Per-PE phase update. Accumulates h = bias + sum(w_j * s_j) over a serial
//   stream of neighbour beats, then sets the self phase from the sign of h.
//   The decided phase feeds the downstream randomiser's in_self_phase input.
//
// Ports
//   clk        : system clock
//   reset      : asynchronous, active-low reset
//   start      : begin an update (only honoured in IDLE)
//   bias       : signed local bias, captured with start
//   nb_valid   : neighbour beat valid
//   nb_ready   : stage accepts a beat (high only in ACCUM)
//   nb_phase   : neighbour phase (0 = +1, 1 = -1)
//   nb_weight  : signed coupling weight
//   nb_last    : final beat of this update
//   self_phase : current decided phase
//   self_valid : one-cycle pulse, self_phase just updated
//   field      : signed field of the last completed update
//   busy       : high in ACCUM or DECIDE
//   err        : sticky beat-count / nb_last mismatch, cleared by next start
// -----------------------------------------------------------------------------
module in_pe_phase_update
  import in_pe_phase_update_pkg::*;
#(
  parameter  int N_NEIGH = PE_N_NEIGH,
  parameter  int W_W     = PE_W_W,
  localparam int ACC_W   = W_W + $clog2(N_NEIGH + 1) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [W_W-1:0]   bias,
  input  logic                    nb_valid,
  output logic                    nb_ready,
  input  phase_t                  nb_phase,
  input  logic signed [W_W-1:0]   nb_weight,
  input  logic                    nb_last,
  output phase_t                  self_phase,
  output logic                    self_valid,
  output logic signed [ACC_W-1:0] field,
  output logic                    busy,
  output logic                    err
);

  localparam int               CNT_W    = $clog2(N_NEIGH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_NEIGH - 1);

  pe_upd_state_e           r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_err;
  logic signed [ACC_W-1:0] r_field;
  phase_t                  r_phase;
  logic                    r_valid;

  pe_upd_state_e           w_state_nxt;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_err_nxt;
  logic signed [ACC_W-1:0] w_field_nxt;
  phase_t                  w_phase_nxt;
  logic                    w_valid_nxt;
  logic                    w_accept;
  logic                    w_cnt_end;

  // Sign-extend before any negation so that -(-2^(W_W-1)) is representable.
  function automatic logic signed [ACC_W-1:0] sext(input logic signed [W_W-1:0] v);
    return {{(ACC_W - W_W){v[W_W-1]}}, v};
  endfunction

  // Spin +1 contributes +w, spin -1 contributes -w.
  function automatic logic signed [ACC_W-1:0] signed_term(input phase_t ph,
                                                          input logic signed [W_W-1:0] w);
    logic signed [ACC_W-1:0] w_ext;
    w_ext = sext(w);
    return (ph == 1'b0) ? w_ext : -w_ext;
  endfunction

  // Positive field -> spin +1, negative -> spin -1, zero keeps the old phase.
  function automatic phase_t decide_phase(input logic signed [ACC_W-1:0] acc,
                                          input phase_t prev);
    if (acc == '0)
      return prev;
    return acc[ACC_W-1];
  endfunction

  assign w_accept  = nb_valid && (r_state == ACCUM);
  assign w_cnt_end = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_field_nxt = r_field;
    w_phase_nxt = r_phase;
    w_valid_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_acc_nxt   = sext(bias);
          w_cnt_nxt   = '0;
          w_err_nxt   = 1'b0;
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (w_accept) begin
          w_acc_nxt = r_acc + signed_term(nb_phase, nb_weight);
          w_cnt_nxt = r_cnt + 1'b1;
          // Either condition ends the stream; disagreement between them is an error.
          if (nb_last || w_cnt_end) begin
            w_state_nxt = DECIDE;
            if (nb_last != w_cnt_end)
              w_err_nxt = 1'b1;
          end
        end
      end
      DECIDE: begin
        w_field_nxt = r_acc;
        w_phase_nxt = decide_phase(r_acc, r_phase);
        w_valid_nxt = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_field <= '0;
      r_phase <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      r_field <= w_field_nxt;
      r_phase <= w_phase_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign nb_ready   = (r_state == ACCUM);
  assign busy       = (r_state != IDLE);
  assign err        = r_err;
  assign field      = r_field;
  assign self_phase = r_phase;
  assign self_valid = r_valid;

endmodule

// File: tb/tb_in_pe_phase_update.sv
`timescale 1ns/1ps
module tb_in_pe_phase_update;
  import in_pe_phase_update_pkg::*;

  localparam int N  = 8;
  localparam int WW = 4;
  localparam int AW = WW + $clog2(N + 1) + 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic signed [WW-1:0] bias;
  logic                 nb_valid;
  logic                 nb_ready;
  phase_t               nb_phase;
  logic signed [WW-1:0] nb_weight;
  logic                 nb_last;
  phase_t               self_phase;
  logic                 self_valid;
  logic signed [AW-1:0] field;
  logic                 busy;
  logic                 err;

  int checks = 0;
  int errors = 0;
  int acc_count = 0;

  always #5 clk = ~clk;

  in_pe_phase_update dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bias       (bias),
    .nb_valid   (nb_valid),
    .nb_ready   (nb_ready),
    .nb_phase   (nb_phase),
    .nb_weight  (nb_weight),
    .nb_last    (nb_last),
    .self_phase (self_phase),
    .self_valid (self_valid),
    .field      (field),
    .busy       (busy),
    .err        (err)
  );

  // Beat handshakes as seen at each active edge.
  always @(posedge clk) begin
    if (nb_valid && nb_ready)
      acc_count++;
  end

  typedef struct {
    int bias;
    int wa; int pa;
    int wb; int pb;
    int last_idx;
    bit gaps;
    int ef; int ep; int ee; int en;
  } vec_t;

  vec_t vecs[6];
  int   wv[N];
  int   pv[N];
  bit   lv[N];
  int   g_f, g_p, g_e, g_n, g_lat;
  int   m_f, m_p, m_e, m_n;
  int   prev_phase;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Field from spec rules: plain integer sum, first terminating beat wins.
  function automatic void model(input int b, input int w[N], input int ph[N], input bit lst[N],
                                input int prev, output int f, output int p, output int e,
                                output int n);
    f = b; e = 0; n = 0;
    for (int t = 0; t < N; t++) begin
      f += (ph[t] == 0) ? w[t] : -w[t];
      n = t + 1;
      if (lst[t] || t == N - 1) begin
        e = (lst[t] != (t == N - 1)) ? 1 : 0;
        break;
      end
    end
    p = (f > 0) ? 0 : (f < 0) ? 1 : prev;
  endfunction

  task automatic run_update(input int b, input int w[N], input int ph[N], input bit lst[N],
                            input bit gaps, output int f, output int p, output int e,
                            output int nacc, output int lat);
    int i, guard, lat_cnt, n0;
    lat = -1;
    n0  = acc_count;
    @(negedge clk);
    start = 1'b1;
    bias  = WW'(b);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("busy_after_start", int'(busy), 1);
    check("err_clear_on_start", int'(err), 0);
    i = 0;
    guard = 0;
    while (i < N && guard < 200) begin
      guard++;
      nb_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      nb_phase  = phase_t'(ph[i]);
      nb_weight = WW'(w[i]);
      nb_last   = lst[i];
      #1;
      if (!nb_ready) break;
      @(posedge clk);
      if (nb_valid) i++;
      #1 nb_valid = 1'b0;
      nb_last = 1'b0;
      @(negedge clk);
    end
    nb_valid = 1'b0;
    nb_last  = 1'b0;
    lat_cnt = 1;
    while (lat_cnt <= 10) begin
      if (self_valid) begin
        lat = lat_cnt;
        break;
      end
      @(negedge clk);
      lat_cnt++;
    end
    f    = int'(field);
    p    = int'(self_phase);
    e    = int'(err);
    nacc = acc_count - n0;
    @(negedge clk);
    check("pulse_one_cycle", int'(self_valid), 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; bias = '0; nb_valid = 1'b0;
    nb_phase = 1'b0; nb_weight = '0; nb_last = 1'b0;

    // Reset held with random inputs
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      start     = 1'($urandom);
      nb_valid  = 1'($urandom);
      nb_phase  = 1'($urandom);
      nb_last   = 1'($urandom);
      nb_weight = WW'($urandom);
      bias      = WW'($urandom);
      @(negedge clk);
      check("rst_self_phase", int'(self_phase), 0);
      check("rst_self_valid", int'(self_valid), 0);
      check("rst_field", int'(field), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_nb_ready", int'(nb_ready), 0);
      check("rst_err", int'(err), 0);
    end
    start = 1'b0; nb_valid = 1'b0; nb_last = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    //         bias wa pa  wb pb last gaps  field ph err beats
    vecs[0] = '{ 0,  3, 0,  3, 0,  7, 1'b0,  24, 0, 0, 8};
    vecs[1] = '{ 2,  3, 1,  3, 1,  7, 1'b1, -22, 1, 0, 8};
    vecs[2] = '{ 0,  2, 0,  2, 1,  7, 1'b0,   0, 1, 0, 8};
    vecs[3] = '{-8, -8, 1, -8, 1,  7, 1'b0,  56, 0, 0, 8};
    vecs[4] = '{ 0,  1, 0,  1, 0,  2, 1'b0,   3, 0, 1, 3};
    vecs[5] = '{ 0, -1, 0, -1, 0, -1, 1'b1,  -8, 1, 1, 8};

    for (int v = 0; v < 6; v++) begin
      for (int t = 0; t < N; t++) begin
        wv[t] = (t < 4) ? vecs[v].wa : vecs[v].wb;
        pv[t] = (t < 4) ? vecs[v].pa : vecs[v].pb;
        lv[t] = (t == vecs[v].last_idx);
      end
      run_update(vecs[v].bias, wv, pv, lv, vecs[v].gaps, g_f, g_p, g_e, g_n, g_lat);
      check($sformatf("vec%0d_field", v), g_f, vecs[v].ef);
      check($sformatf("vec%0d_phase", v), g_p, vecs[v].ep);
      check($sformatf("vec%0d_err", v), g_e, vecs[v].ee);
      check($sformatf("vec%0d_beats", v), g_n, vecs[v].en);
      check($sformatf("vec%0d_latency", v), g_lat, 2);
    end
    prev_phase = vecs[5].ep;

    // Randomised updates against the reference model
    for (int r = 0; r < 25; r++) begin
      int rb;
      bit rg;
      rb = int'($urandom_range(0, 15)) - 8;
      rg = 1'($urandom);
      for (int t = 0; t < N; t++) begin
        wv[t] = int'($urandom_range(0, 15)) - 8;
        pv[t] = int'($urandom_range(0, 1));
        lv[t] = ($urandom_range(0, 5) == 0);
      end
      model(rb, wv, pv, lv, prev_phase, m_f, m_p, m_e, m_n);
      run_update(rb, wv, pv, lv, rg, g_f, g_p, g_e, g_n, g_lat);
      check($sformatf("rnd%0d_field", r), g_f, m_f);
      check($sformatf("rnd%0d_phase", r), g_p, m_p);
      check($sformatf("rnd%0d_err", r), g_e, m_e);
      check($sformatf("rnd%0d_beats", r), g_n, m_n);
      check($sformatf("rnd%0d_latency", r), g_lat, 2);
      prev_phase = m_p;
    end

    // Drive self_phase to 1 so the abort reset is observable
    for (int t = 0; t < N; t++) begin
      wv[t] = 0; pv[t] = 0; lv[t] = (t == N - 1);
    end
    run_update(-1, wv, pv, lv, 1'b0, g_f, g_p, g_e, g_n, g_lat);
    check("pre_abort_phase", g_p, 1);
    check("pre_abort_field", g_f, -1);

    // Abort mid-update with asynchronous reset
    begin
      bit seen;
      @(negedge clk);
      start = 1'b1;
      bias  = '0;
      @(posedge clk);
      #1 start = 1'b0;
      for (int t = 0; t < 4; t++) begin
        nb_valid  = 1'b1;
        nb_phase  = 1'b1;
        nb_weight = 4'sd3;
        nb_last   = 1'b0;
        @(posedge clk);
        #1;
      end
      nb_valid = 1'b0;
      #1 reset = 1'b0;
      #1;
      check("abort_busy", int'(busy), 0);
      check("abort_nb_ready", int'(nb_ready), 0);
      check("abort_self_phase", int'(self_phase), 0);
      check("abort_field", int'(field), 0);
      seen = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (6) begin
        @(negedge clk);
        if (self_valid) seen = 1'b1;
      end
      check("abort_no_self_valid", int'(seen), 0);
      check("abort_idle_after", int'(busy), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
